cpu_trace_printer: RTL and testbench

- Formats one CPU write-back record per handshake into the ASCII trace line our trace checker parses, emitting one character per accepted output beat.
- Register write line: `^<time>@<pc>: $<grf> <= <data>#`
- Memory write line: `^<time>@<pc>: *<addr> <= <data>#`
- Sits between the CPU's commit stage and the trace/UART sink.

---
 rtl/cpu_trace_printer_pkg.sv | 59 +++++
 rtl/cpu_trace_printer_bin2bcd.sv | 63 ++++++
 rtl/cpu_trace_printer.sv | 164 ++++++++++++++++
 tb/tb_cpu_trace_printer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_printer_pkg.sv
// Shared constants for the CPU trace printer: ASCII codes, FSM and field encodings.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cpu_trace_printer_pkg;

    localparam int MAX_TIME = 9999;

    localparam logic [7:0] CH_CARET = 8'h5E;  // '^'
    localparam logic [7:0] CH_AT    = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON = 8'h3A;  // ':'
    localparam logic [7:0] CH_SP    = 8'h20;  // ' '
    localparam logic [7:0] CH_DOLLAR= 8'h24;  // '$'
    localparam logic [7:0] CH_STAR  = 8'h2A;  // '*'
    localparam logic [7:0] CH_LT    = 8'h3C;  // '<'
    localparam logic [7:0] CH_EQ    = 8'h3D;  // '='
    localparam logic [7:0] CH_HASH  = 8'h23;  // '#'
    localparam logic [7:0] CH_0     = 8'h30;  // '0'
    localparam logic [7:0] CH_A     = 8'h61;  // 'a'

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // TIME carries the leading '^', PC carries the leading '@'.
    localparam logic [3:0] F_TIME  = 4'd0;
    localparam logic [3:0] F_PC    = 4'd1;
    localparam logic [3:0] F_COLON = 4'd2;
    localparam logic [3:0] F_SP    = 4'd3;
    localparam logic [3:0] F_TAG   = 4'd4;
    localparam logic [3:0] F_GRF   = 4'd5;
    localparam logic [3:0] F_ADDR  = 4'd6;
    localparam logic [3:0] F_ARROW = 4'd7;
    localparam logic [3:0] F_DATA  = 4'd8;
    localparam logic [3:0] F_HASH  = 4'd9;

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return CH_0 + {4'b0, n};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (CH_0 + {4'b0, n}) : (CH_A + {4'b0, n} - 8'd10);
    endfunction

    // k = 0 selects the most significant nibble.
    function automatic logic [3:0] nibble(input logic [31:0] v, input logic [2:0] k);
        return v[{~k, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] grf_tens(input logic [4:0] g);
        return (g >= 5'd30) ? 2'd3 : (g >= 5'd20) ? 2'd2 : (g >= 5'd10) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [3:0] grf_units(input logic [4:0] g);
        logic [4:0] u;
        u = g - 5'd10 * {3'b0, grf_tens(g)};
        return u[3:0];
    endfunction

endpackage

// File: rtl/cpu_trace_printer_bin2bcd.sv
// Iterative shift/add-3 binary to 4-digit BCD converter with digit count.
// Latency: done pulses W edges after the start edge.
// Backpressure: none; a new start restarts the conversion.
module bin2bcd_iter #(
    parameter int W = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [W-1:0]  i_bin,
    output logic          o_done,
    output logic [15:0]   o_digits,
    output logic [2:0]    o_ndig
);
    logic [W-1:0] r_bin;
    logic [15:0]  r_bcd;
    logic [3:0]   r_cnt;
    logic         r_busy;
    logic         r_done;
    logic [15:0]  w_adj;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // One input bit shifted into the BCD register per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bin  <= i_bin;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= {w_adj[14:0], r_bin[W-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'(W-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done   = r_done;
    assign o_digits = r_bcd;
    assign o_ndig   = (r_bcd[15:12] != 4'd0) ? 3'd4 :
                      (r_bcd[11:8]  != 4'd0) ? 3'd3 :
                      (r_bcd[7:4]   != 4'd0) ? 3'd2 : 3'd1;
endmodule

// File: rtl/cpu_trace_printer.sv
// Formats one CPU write-back record into an ASCII trace line, one char per beat.
// Latency: '^' presented TIME_W+1 edges after accept; then one char per accepted beat.
// Backpressure: out_* held while out_ready low; in_ready low until '#' is accepted.
module cpu_trace_printer #(
    parameter int TIME_W   = 14,
    parameter int MAX_TIME = cpu_trace_printer_pkg::MAX_TIME
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_grf,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              drop
);
    import cpu_trace_printer_pkg::*;

    logic [1:0]  r_state;
    logic        r_kind;
    logic [31:0] r_pc;
    logic [4:0]  r_grf;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_field;
    logic [3:0]  r_idx;
    logic        r_drop;

    logic        w_accept;
    logic        w_printable;
    logic        w_fire;
    logic        w_done;
    logic [15:0] w_digits;
    logic [2:0]  w_ndig;
    logic [2:0]  w_tpos;
    logic [2:0]  w_hex_k;
    logic [1:0]  w_tens;
    logic [3:0]  w_units;
    logic [3:0]  w_last_idx;
    logic [3:0]  w_next_field;
    logic [7:0]  w_char;

    assign in_ready    = reset && (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_printable = (in_time != '0) && (32'(in_time) <= 32'(MAX_TIME))
                         && !(!in_kind && (in_grf == 5'd0));
    assign out_valid   = (r_state == ST_EMIT);
    assign w_fire      = out_valid && out_ready;

    bin2bcd_iter #(.W(TIME_W)) u_bcd (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_accept && w_printable),
        .i_bin    (in_time),
        .o_done   (w_done),
        .o_digits (w_digits),
        .o_ndig   (w_ndig)
    );

    assign w_tpos  = w_ndig - r_idx[2:0];
    assign w_hex_k = r_idx[2:0] - 3'd1;
    assign w_tens  = grf_tens(r_grf);
    assign w_units = grf_units(r_grf);

    // Last index of the current field, and which field follows it.
    always_comb begin
        w_last_idx   = 4'd0;
        w_next_field = F_HASH;
        case (r_field)
            F_TIME:  begin w_last_idx = {1'b0, w_ndig};   w_next_field = F_PC;    end
            F_PC:    begin w_last_idx = 4'd8;             w_next_field = F_COLON; end
            F_COLON: begin w_last_idx = 4'd0;             w_next_field = F_SP;    end
            F_SP:    begin w_last_idx = 4'd0;             w_next_field = F_TAG;   end
            F_TAG:   begin w_last_idx = 4'd0;             w_next_field = r_kind ? F_ADDR : F_GRF; end
            F_GRF:   begin w_last_idx = (w_tens != 2'd0) ? 4'd1 : 4'd0; w_next_field = F_ARROW; end
            F_ADDR:  begin w_last_idx = 4'd7;             w_next_field = F_ARROW; end
            F_ARROW: begin w_last_idx = 4'd3;             w_next_field = F_DATA;  end
            F_DATA:  begin w_last_idx = 4'd7;             w_next_field = F_HASH;  end
            default: begin w_last_idx = 4'd0;             w_next_field = F_HASH;  end
        endcase
    end

    // Character for the current field/index; zero whenever nothing is offered.
    always_comb begin
        w_char = 8'h00;
        if (r_state == ST_EMIT) begin
            case (r_field)
                F_TIME:  w_char = (r_idx == 4'd0) ? CH_CARET
                                : dec_char(w_digits[{w_tpos[1:0], 2'b00} +: 4]);
                F_PC:    w_char = (r_idx == 4'd0) ? CH_AT : hex_char(nibble(r_pc, w_hex_k));
                F_COLON: w_char = CH_COLON;
                F_SP:    w_char = CH_SP;
                F_TAG:   w_char = r_kind ? CH_STAR : CH_DOLLAR;
                F_GRF:   w_char = (w_tens != 2'd0 && r_idx == 4'd0) ? dec_char({2'b0, w_tens})
                                : dec_char(w_units);
                F_ADDR:  w_char = hex_char(nibble(r_addr, r_idx[2:0]));
                F_ARROW: w_char = (r_idx == 4'd1) ? CH_LT : (r_idx == 4'd2) ? CH_EQ : CH_SP;
                F_DATA:  w_char = hex_char(nibble(r_data, r_idx[2:0]));
                default: w_char = CH_HASH;
            endcase
        end
    end

    assign out_char = w_char;
    assign out_last = out_valid && (r_field == F_HASH);
    assign drop     = r_drop;

    // Accept/drop decision, conversion wait, and sequencer advance on each fired beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_kind  <= 1'b0;
            r_pc    <= '0;
            r_grf   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_field <= F_TIME;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_accept && !w_printable;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_kind <= in_kind;
                        r_pc   <= in_pc;
                        r_grf  <= in_grf;
                        r_addr <= in_addr;
                        r_data <= in_data;
                        if (w_printable)
                            r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_done) begin
                        r_state <= ST_EMIT;
                        r_field <= F_TIME;
                        r_idx   <= '0;
                    end
                end
                ST_EMIT: begin
                    if (w_fire) begin
                        if (r_idx == w_last_idx) begin
                            if (r_field == F_HASH)
                                r_state <= ST_IDLE;
                            r_field <= w_next_field;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_trace_printer.sv
// Directed, table-driven bench for cpu_trace_printer with backpressure and reset sequences.
// Latency: checks '^' arrives TIME_W+1 edges after accept.
// Backpressure: drives out_ready stall patterns and checks held outputs.
module tb_cpu_trace_printer;
    localparam int TIME_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_kind;
    logic [TIME_W-1:0] in_time;
    logic [31:0]       in_pc;
    logic [4:0]        in_grf;
    logic [31:0]       in_addr;
    logic [31:0]       in_data;
    logic [7:0]        out_char;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              drop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_trace_printer #(.TIME_W(TIME_W), .MAX_TIME(9999)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_time   (in_time),
        .in_pc     (in_pc),
        .in_grf    (in_grf),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .drop      (drop)
    );

    typedef struct {
        bit          kind;
        int unsigned t;
        logic [31:0] pc;
        logic [4:0]  grf;
        logic [31:0] addr;
        logic [31:0] data;
        bit          drop;
        string       exp;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(bit k, int unsigned t, logic [31:0] pc, logic [4:0] g,
                                logic [31:0] a, logic [31:0] d, bit dr, string e);
        vec_t v;
        v.kind = k; v.t = t; v.pc = pc; v.grf = g; v.addr = a; v.data = d; v.drop = dr; v.exp = e;
        return v;
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    // Offer one record, then collect its line (or verify the drop). stall applies the
    // 1,0,0,1 out_ready pattern inside the pc field; abort_after>0 stops after that many chars.
    task automatic run_line(input vec_t v, input bit stall, input int abort_after, input string tag);
        string      got;
        int         n, lc, lat, stalls;
        bit         started, done, gap, busy_rdy, unstable, early_last, seen_vld;
        logic [7:0] held;
        bit         was_stall;
        got = ""; n = 0; lc = 0; lat = -1; stalls = 0;
        started = 0; done = 0; gap = 0; busy_rdy = 0; unstable = 0; early_last = 0; seen_vld = 0;
        held = 8'h00; was_stall = 0;

        @(negedge clk);
        in_kind  = v.kind;
        in_time  = v.t[TIME_W-1:0];
        in_pc    = v.pc;
        in_grf   = v.grf;
        in_addr  = v.addr;
        in_data  = v.data;
        in_valid = 1'b1;
        out_ready = 1'b1;
        check(in_ready == 1'b1, {tag, " in_ready_before"}, $sformatf("%0b", in_ready), "1");
        @(negedge clk);
        in_valid = 1'b0;

        if (v.drop) begin
            check(drop == 1'b1, {tag, " drop_pulse"}, $sformatf("%0b", drop), "1");
            check(in_ready == 1'b1, {tag, " in_ready_after_drop"}, $sformatf("%0b", in_ready), "1");
            @(negedge clk);
            check(drop == 1'b0, {tag, " drop_one_cycle"}, $sformatf("%0b", drop), "0");
            repeat (20) begin
                if (out_valid) seen_vld = 1;
                @(negedge clk);
            end
            check(!seen_vld, {tag, " no_output"}, $sformatf("%0b", seen_vld), "0");
            return;
        end

        check(drop == 1'b0, {tag, " no_drop"}, $sformatf("%0b", drop), "0");
        while (n < 300 && !done) begin
            if (out_valid && !started) begin
                started = 1;
                lat = n;
            end
            out_ready = (stall && started) ? !(lc inside {5, 6, 9, 10}) : 1'b1;
            if (in_ready) busy_rdy = 1;
            if (out_valid) begin
                if (was_stall && out_char != held) unstable = 1;
                if (!out_ready) stalls++;
                if (out_ready) begin
                    got = {got, $sformatf("%c", out_char)};
                    if (out_last) done = 1;
                end
                if (out_last && got.len() != v.exp.len()) early_last = 1;
                was_stall = !out_ready;
                held = out_char;
                if (abort_after > 0 && got.len() == abort_after) return;
            end else if (started) begin
                gap = 1;
            end
            if (started) lc++;
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end

        check(done, {tag, " line_done"}, $sformatf("%0b", done), "1");
        check(got == v.exp, {tag, " text"}, got, v.exp);
        check(lat == TIME_W + 1, {tag, " latency"}, $sformatf("%0d", lat), $sformatf("%0d", TIME_W + 1));
        check(!early_last, {tag, " out_last_only_on_hash"}, $sformatf("%0b", early_last), "0");
        check(!gap, {tag, " valid_continuous"}, $sformatf("%0b", gap), "0");
        check(!busy_rdy, {tag, " in_ready_low_busy"}, $sformatf("%0b", busy_rdy), "0");
        if (stall) begin
            check(stalls == 4, {tag, " stall_cycles"}, $sformatf("%0d", stalls), "4");
            check(!unstable, {tag, " held_while_stalled"}, $sformatf("%0b", unstable), "0");
        end
        @(negedge clk);
        out_ready = 1'b1;
        check(out_valid == 1'b0, {tag, " valid_gap_after"}, $sformatf("%0b", out_valid), "0");
        check(in_ready == 1'b1, {tag, " ready_after"}, $sformatf("%0b", in_ready), "1");
    endtask

    initial begin
        vecs[0] = mk(0, 25,    32'h0000_3000, 5'd5,  32'h0,          32'h1234_abcd, 0,
                     "^25@00003000: $5 <= 1234abcd#");
        vecs[1] = mk(1, 9999,  32'h0000_4ffc, 5'd0,  32'h0000_2ffc, 32'hffff_ffff, 0,
                     "^9999@00004ffc: *00002ffc <= ffffffff#");
        vecs[2] = mk(0, 1,     32'h0000_0000, 5'd31, 32'h0,          32'h0000_0000, 0,
                     "^1@00000000: $31 <= 00000000#");
        vecs[3] = mk(0, 1000,  32'hdead_beef, 5'd9,  32'h0,          32'hcafe_f00d, 0,
                     "^1000@deadbeef: $9 <= cafef00d#");
        vecs[4] = mk(0, 10,    32'h0000_0010, 5'd10, 32'h0,          32'h0000_000a, 0,
                     "^10@00000010: $10 <= 0000000a#");
        vecs[5] = mk(1, 7,     32'h0000_abcd, 5'd0,  32'h89ab_cdef, 32'h0123_4567, 0,
                     "^7@0000abcd: *89abcdef <= 01234567#");
        vecs[6] = mk(0, 0,     32'h0000_3000, 5'd5,  32'h0,          32'h0,          1, "");
        vecs[7] = mk(1, 10000, 32'h0000_3000, 5'd5,  32'h0,          32'h0,          1, "");
        vecs[8] = mk(0, 5,     32'h0000_3000, 5'd0,  32'h0,          32'h0,          1, "");

        reset = 1'b0; in_valid = 1'b0; in_kind = 1'b0; in_time = '0; in_pc = '0;
        in_grf = '0; in_addr = '0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check(in_ready == 1'b0,   "reset in_ready",  $sformatf("%0b", in_ready), "0");
        check(out_valid == 1'b0,  "reset out_valid", $sformatf("%0b", out_valid), "0");
        check(out_char == 8'h00,  "reset out_char",  $sformatf("%0h", out_char), "0");
        check(out_last == 1'b0,   "reset out_last",  $sformatf("%0b", out_last), "0");
        check(drop == 1'b0,       "reset drop",      $sformatf("%0b", drop), "0");
        reset = 1'b1;

        for (int i = 0; i < 9; i++)
            run_line(vecs[i], 1'b0, 0, $sformatf("vec%0d", i));

        // Stall twice inside the pc field.
        run_line(vecs[0], 1'b1, 0, "backpressure");

        // Reset after 10 chars with a record held on in_valid; then a clean line.
        run_line(vecs[1], 1'b0, 10, "abort");
        reset    = 1'b0;
        in_valid = 1'b1;
        in_kind  = 1'b0; in_time = 14'd25; in_grf = 5'd5;
        @(negedge clk);
        check(out_valid == 1'b0, "midreset out_valid", $sformatf("%0b", out_valid), "0");
        check(out_char == 8'h00, "midreset out_char",  $sformatf("%0h", out_char), "0");
        check(in_ready == 1'b0,  "midreset in_ready",  $sformatf("%0b", in_ready), "0");
        @(negedge clk);
        check(drop == 1'b0,      "midreset drop",      $sformatf("%0b", drop), "0");
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "postreset idle",     $sformatf("%0b", out_valid), "0");
        run_line(vecs[1], 1'b0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
